// File: rtl/pi_incremental_mc_pkg.sv
`default_nettype none
//==============================================================================
// Module   : pi_incremental_mc_pkg
// Desc     : Shared constants and derived-width helpers for the PI controllers.
// Revision : 1.0 - initial release
//==============================================================================
package pi_incremental_mc_pkg;

    localparam int PI_INC_LATENCY = 3;

    function automatic int de_width(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int prod_width(input int data_w, input int coef_w);
        return de_width(data_w) + coef_w;
    endfunction

    // Two guard bits: one for p+i, one for adding u_prev.
    function automatic int acc_width(input int data_w, input int coef_w);
        return prod_width(data_w, coef_w) + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pi_incremental_mc_sat_clamp.sv
`default_nettype none
//==============================================================================
// Module   : sat_clamp
// Desc     : Clamp a wide signed value into [lo, hi]; flags when clamping.
// Revision : 1.0 - initial release
//==============================================================================
module sat_clamp #(
    parameter int IN_W  = 35,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    input  logic signed [OUT_W-1:0] lo,
    input  logic signed [OUT_W-1:0] hi,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    logic signed [IN_W-1:0] w_lo;
    logic signed [IN_W-1:0] w_hi;

    assign w_lo = IN_W'(lo);
    assign w_hi = IN_W'(hi);

    always_comb begin
        dout = din[OUT_W-1:0];
        sat  = 1'b0;
        if (din < w_lo) begin
            dout = lo;
            sat  = 1'b1;
        end else if (din > w_hi) begin
            dout = hi;
            sat  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pi_incremental_mc.sv
`default_nettype none
//==============================================================================
// Module   : pi_incremental_mc
// Desc     : Multi-channel pipelined velocity-form PI controller with clamping.
// Revision : 1.0 - initial release
//==============================================================================
module pi_incremental_mc
    import pi_incremental_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int COEF_FRAC  = 8,
    parameter int CHANNELS   = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic signed [COEF_WIDTH-1:0] kp,
    input  logic signed [COEF_WIDTH-1:0] ki,
    input  logic signed [DATA_WIDTH-1:0] out_min,
    input  logic signed [DATA_WIDTH-1:0] out_max,
    input  logic signed [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic        [ID_WIDTH-1:0]   s_axis_tid,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic signed [DATA_WIDTH-1:0] m_axis_tdata,
    output logic        [ID_WIDTH-1:0]   m_axis_tid,
    output logic                         m_axis_tuser,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready
);

    localparam int DE_W   = de_width(DATA_WIDTH);
    localparam int PROD_W = prod_width(DATA_WIDTH, COEF_WIDTH);
    localparam int ACC_W  = acc_width(DATA_WIDTH, COEF_WIDTH);
    localparam int SLOTS  = 2 ** ID_WIDTH;

    // Arrays cover the whole tid space; slots >= CHANNELS are never written.
    logic signed [DATA_WIDTH-1:0] r_e_prev [SLOTS];
    logic signed [DATA_WIDTH-1:0] r_u_prev [SLOTS];

    logic                         w_advance;
    logic                         w_accept;
    logic                         w_in_range;
    logic signed [DE_W-1:0]       w_de;

    logic                         r_s1_valid;
    logic        [ID_WIDTH-1:0]   r_s1_id;
    logic signed [DATA_WIDTH-1:0] r_s1_e;
    logic signed [DE_W-1:0]       r_s1_de;
    logic signed [COEF_WIDTH-1:0] r_s1_kp;
    logic signed [COEF_WIDTH-1:0] r_s1_ki;
    logic signed [DATA_WIDTH-1:0] r_s1_min;
    logic signed [DATA_WIDTH-1:0] r_s1_max;

    logic signed [PROD_W-1:0]     w_p;
    logic signed [PROD_W-1:0]     w_i;

    logic                         r_s2_valid;
    logic        [ID_WIDTH-1:0]   r_s2_id;
    logic signed [PROD_W-1:0]     r_s2_p;
    logic signed [PROD_W-1:0]     r_s2_i;
    logic signed [DATA_WIDTH-1:0] r_s2_min;
    logic signed [DATA_WIDTH-1:0] r_s2_max;

    logic signed [ACC_W-1:0]      w_sum;
    logic signed [ACC_W-1:0]      w_s;
    logic signed [ACC_W-1:0]      w_v;
    logic signed [DATA_WIDTH-1:0] w_y;
    logic                         w_sat;

    logic                         r_m_valid;
    logic signed [DATA_WIDTH-1:0] r_m_data;
    logic        [ID_WIDTH-1:0]   r_m_id;
    logic                         r_m_user;

    assign w_advance     = !r_m_valid || m_axis_tready;
    assign s_axis_tready = w_advance && !clear;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_in_range    = int'(s_axis_tid) < CHANNELS;

    assign w_de  = DE_W'(s_axis_tdata) - DE_W'(r_e_prev[s_axis_tid]);
    assign w_p   = PROD_W'(r_s1_kp) * PROD_W'(r_s1_de);
    assign w_i   = PROD_W'(r_s1_ki) * PROD_W'(r_s1_e);

    assign w_sum = ACC_W'(r_s2_p) + ACC_W'(r_s2_i);
    assign w_s   = w_sum >>> COEF_FRAC;
    assign w_v   = ACC_W'(r_u_prev[r_s2_id]) + w_s;

    sat_clamp #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_WIDTH)
    ) u_sat_clamp (
        .din  (w_v),
        .lo   (r_s2_min),
        .hi   (r_s2_max),
        .dout (w_y),
        .sat  (w_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_e     <= '0;
            r_s1_de    <= '0;
            r_s1_kp    <= '0;
            r_s1_ki    <= '0;
            r_s1_min   <= '0;
            r_s1_max   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_p     <= '0;
            r_s2_i     <= '0;
            r_s2_min   <= '0;
            r_s2_max   <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_id     <= '0;
            r_m_user   <= 1'b0;
        end else if (w_advance) begin
            // Out-of-range channels are swallowed here: they never become valid.
            r_s1_valid <= w_accept && w_in_range;
            if (w_accept) begin
                r_s1_id  <= s_axis_tid;
                r_s1_e   <= s_axis_tdata;
                r_s1_de  <= w_de;
                r_s1_kp  <= kp;
                r_s1_ki  <= ki;
                r_s1_min <= out_min;
                r_s1_max <= out_max;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_id  <= r_s1_id;
                r_s2_p   <= w_p;
                r_s2_i   <= w_i;
                r_s2_min <= r_s1_min;
                r_s2_max <= r_s1_max;
            end
            r_m_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_m_data <= w_y;
                r_m_id   <= r_s2_id;
                r_m_user <= w_sat;
            end
        end
    end

    // Storing the clamped output (not the raw sum) is what prevents windup.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_e_prev[i] <= '0;
                r_u_prev[i] <= '0;
            end
        end else begin
            if (w_accept && w_in_range) r_e_prev[s_axis_tid] <= s_axis_tdata;
            if (w_advance && r_s2_valid) r_u_prev[r_s2_id] <= w_y;
        end
    end

    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tid    = r_m_id;
    assign m_axis_tuser  = r_m_user;

endmodule
`default_nettype wire
